// File: rtl/cp0_timer_regfile.sv
// CP0 register file: Count/Compare timer, synchronised hardware interrupts,
// precise exception commit and ERET. Define CP0_TIMER_INT_EN to build the Compare/TI timer.
module cp0_timer_regfile #(
    parameter int WIDTH = 32,
    parameter int HW_INT_NUM = 6,
    parameter int COUNT_DIV = 2,
    parameter logic [31:0] PRID_VALUE = 32'h0000_4220,
    parameter logic [31:0] CONFIG_RST = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HW_INT_NUM-1:0] hw_int,
    input  logic                  mtc0_we,
    input  logic [4:0]            waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [4:0]            raddr,
    output logic [WIDTH-1:0]      rdata,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic                  exc_bd,
    input  logic [WIDTH-1:0]      exc_pc,
    input  logic [WIDTH-1:0]      exc_badvaddr,
    input  logic                  eret,
    output logic [WIDTH-1:0]      status_o,
    output logic [WIDTH-1:0]      cause_o,
    output logic [WIDTH-1:0]      epc_o,
    output logic                  int_req,
    output logic                  timer_int,
    output logic                  kernel_mode
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);
    localparam logic [WIDTH-1:0] STATUS_RST   = WIDTH'(32'h0040_0000);
    localparam logic [WIDTH-1:0] STATUS_WMASK = WIDTH'(32'h0000_FF03);

    logic [WIDTH-1:0]      badvaddr_q, badvaddr_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      status_q, status_d;
    logic [WIDTH-1:0]      epc_q, epc_d;
    logic [WIDTH-1:0]      config_q, config_d;
    logic                  bd_q, bd_d;
    logic [1:0]            ip_sw_q, ip_sw_d;
    logic [4:0]            exc_code_q, exc_code_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [HW_INT_NUM-1:0] sync1_q, sync2_q;
    logic                  wr_sys, wr_cnt;
    logic                  ti_bit;
    logic [5:0]            hw_ip;
    logic [7:0]            ip_vec;
    logic [WIDTH-1:0]      compare_rd;

    // Status/Cause/EPC writes yield to both exc and eret; Count/Compare/Config only to exc.
    assign wr_sys = mtc0_we & ~exc_valid & ~eret;
    assign wr_cnt = mtc0_we & ~exc_valid;

`ifdef CP0_TIMER_INT_EN
    logic [WIDTH-1:0] compare_q, compare_d;
    logic             ti_q, ti_d;

    always_comb begin
        compare_d = compare_q;
        ti_d      = ti_q;
        if (wr_cnt && waddr == REG_COMPARE) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end else if (count_d == compare_d) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign ti_bit     = ti_q;
    assign compare_rd = compare_q;
`else
    assign ti_bit     = 1'b0;
    assign compare_rd = '0;
`endif

    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        status_d   = status_q;
        epc_d      = epc_q;
        config_d   = config_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exc_code_d = exc_code_q;
        div_d      = div_q;

        if (div_q == DIV_LAST) begin
            div_d   = '0;
            count_d = count_q + WIDTH'(1);
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if (wr_cnt && waddr == REG_COUNT) begin
            count_d = wdata;
            div_d   = '0;
        end
        if (wr_cnt && waddr == REG_CONFIG) begin
            config_d = {config_q[WIDTH-1:3], wdata[2:0]};
        end

        if (wr_sys) begin
            case (waddr)
                REG_STATUS: status_d = (status_q & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
                REG_CAUSE:  ip_sw_d  = wdata[9:8];
                REG_EPC:    epc_d    = wdata;
                default:    ;
            endcase
        end

        // A nested exception keeps the EPC/BD of the original fault.
        if (exc_valid) begin
            if (!status_q[1]) begin
                epc_d = exc_bd ? (exc_pc - WIDTH'(4)) : exc_pc;
                bd_d  = exc_bd;
            end
            status_d[1] = 1'b1;
            exc_code_d  = exc_code;
            if (exc_code == 5'd4 || exc_code == 5'd5) begin
                badvaddr_d = exc_badvaddr;
            end
        end else if (eret) begin
            status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            status_q   <= STATUS_RST;
            epc_q      <= '0;
            config_q   <= WIDTH'(CONFIG_RST);
            bd_q       <= 1'b0;
            ip_sw_q    <= '0;
            exc_code_q <= '0;
            div_q      <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            config_q   <= config_d;
            bd_q       <= bd_d;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
            div_q      <= div_d;
            sync1_q    <= hw_int;
            sync2_q    <= sync1_q;
        end
    end

    always_comb begin
        hw_ip = '0;
        hw_ip[HW_INT_NUM-1:0] = sync2_q;
        ip_vec = {hw_ip[5] | ti_bit, hw_ip[4:0], ip_sw_q};

        cause_o        = '0;
        cause_o[31]    = bd_q;
        cause_o[30]    = ti_bit;
        cause_o[15:8]  = ip_vec;
        cause_o[6:2]   = exc_code_q;
    end

    always_comb begin
        case (raddr)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count_q;
            REG_COMPARE:  rdata = compare_rd;
            REG_STATUS:   rdata = status_q;
            REG_CAUSE:    rdata = cause_o;
            REG_EPC:      rdata = epc_q;
            REG_PRID:     rdata = WIDTH'(PRID_VALUE);
            REG_CONFIG:   rdata = config_q;
            default:      rdata = '0;
        endcase
    end

    assign status_o    = status_q;
    assign epc_o       = epc_q;
    assign kernel_mode = status_q[1];
    assign timer_int   = ti_bit;
    assign int_req     = status_q[0] & ~status_q[1] & |(ip_vec & status_q[15:8]);

endmodule

// File: tb/tb_cp0_timer_regfile.sv
// Directed self-checking bench for cp0_timer_regfile with hand-computed expectations.
module tb_cp0_timer_regfile;

    logic        clk;
    logic        rst;
    logic [5:0]  hw_int;
    logic        mtc0_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_pc;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        int_req;
    logic        timer_int;
    logic        kernel_mode;

    int compare_cnt  = 0;
    int mismatch_cnt = 0;
    logic [31:0] rd;

    cp0_timer_regfile #(
        .WIDTH(32), .HW_INT_NUM(6), .COUNT_DIV(2),
        .PRID_VALUE(32'h0000_4220), .CONFIG_RST(32'h8000_0000)
    ) dut (
        .clk(clk), .rst(rst), .hw_int(hw_int),
        .mtc0_we(mtc0_we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_bd(exc_bd),
        .exc_pc(exc_pc), .exc_badvaddr(exc_badvaddr), .eret(eret),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
        .int_req(int_req), .timer_int(timer_int), .kernel_mode(kernel_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compare_cnt++;
        if (obs !== exp) begin
            mismatch_cnt++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1'b1;
        waddr   = a;
        wdata   = d;
        tick();
        mtc0_we = 1'b0;
    endtask

    task automatic readReg(input logic [4:0] a, output logic [31:0] v);
        raddr = a;
        #1;
        v = rdata;
    endtask

    task automatic commitExc(input logic bd, input logic [31:0] pc, input logic [4:0] code,
                             input logic [31:0] bva);
        exc_valid    = 1'b1;
        exc_bd       = bd;
        exc_pc       = pc;
        exc_code     = code;
        exc_badvaddr = bva;
        tick();
        exc_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; hw_int = '0; mtc0_we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        exc_valid = 1'b0; exc_code = '0; exc_bd = 1'b0; exc_pc = '0; exc_badvaddr = '0;
        eret = 1'b0;
        tick();
        tick();

        checkOutput("rst_status", status_o, 32'h0040_0000);
        checkOutput("rst_cause", cause_o, 32'h0);
        checkOutput("rst_epc", epc_o, 32'h0);
        checkOutput("rst_flags", {29'd0, int_req, timer_int, kernel_mode}, 32'h0);
        readReg(5'd16, rd);
        checkOutput("rst_config", rd, 32'h8000_0000);
        readReg(5'd15, rd);
        checkOutput("rst_prid", rd, 32'h0000_4220);

        rst = 1'b1;
        tick();

`ifdef CP0_TIMER_INT_EN
        applyStimulus(5'd9, 32'h0);
        applyStimulus(5'd11, 32'h5);
        applyStimulus(5'd12, 32'h0000_8001);
        checkOutput("status_mask", status_o, 32'h0040_8001);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("ti_before", {31'd0, timer_int}, 32'h0);
        tick();
        checkOutput("ti_set", {30'd0, timer_int, int_req}, 32'h3);
        checkOutput("ip7_ti", {31'd0, cause_o[15]}, 32'h1);
        readReg(5'd9, rd);
        checkOutput("count_at_match", rd, 32'h5);
        applyStimulus(5'd11, 32'd100);
        checkOutput("ti_clear", {30'd0, timer_int, int_req}, 32'h0);

        applyStimulus(5'd9, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        applyStimulus(5'd11, 32'h3);
        checkOutput("collision_ti", {31'd0, timer_int}, 32'h0);
        readReg(5'd9, rd);
        checkOutput("collision_count", rd, 32'h3);
        applyStimulus(5'd11, 32'd1000);
`else
        applyStimulus(5'd11, 32'h5);
        readReg(5'd11, rd);
        checkOutput("compare_absent", rd, 32'h0);
        applyStimulus(5'd9, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        readReg(5'd9, rd);
        checkOutput("count_run", rd, 32'h5);
        checkOutput("ti_absent", {31'd0, timer_int}, 32'h0);
`endif
        applyStimulus(5'd12, 32'h0);

        // Delay-slot exception with a colliding EPC write that must lose.
        mtc0_we = 1'b1; waddr = 5'd14; wdata = 32'hDEAD_BEEF;
        commitExc(1'b1, 32'hBFC0_0104, 5'd5, 32'h1234_5679);
        mtc0_we = 1'b0;
        checkOutput("exc_epc", epc_o, 32'hBFC0_0100);
        checkOutput("exc_bd_code", {26'd0, cause_o[31], cause_o[6:2]}, 32'h25);
        readReg(5'd8, rd);
        checkOutput("exc_badvaddr", rd, 32'h1234_5679);
        checkOutput("exc_exl", {31'd0, kernel_mode}, 32'h1);

        commitExc(1'b0, 32'h8000_0180, 5'd4, 32'hAAAA_0000);
        checkOutput("nest_epc", epc_o, 32'hBFC0_0100);
        checkOutput("nest_bd_code", {26'd0, cause_o[31], cause_o[6:2]}, 32'h24);
        readReg(5'd8, rd);
        checkOutput("nest_badvaddr", rd, 32'hAAAA_0000);

        eret = 1'b1;
        tick();
        eret = 1'b0;
        checkOutput("eret_exl", {31'd0, kernel_mode}, 32'h0);
        checkOutput("eret_epc", epc_o, 32'hBFC0_0100);

        applyStimulus(5'd12, 32'h0000_0001);
        commitExc(1'b0, 32'h0000_0100, 5'd0, 32'h0000_0005);
        checkOutput("int_exc_epc", epc_o, 32'h0000_0100);
        readReg(5'd8, rd);
        checkOutput("int_exc_badv_kept", rd, 32'hAAAA_0000);
        eret = 1'b1;
        applyStimulus(5'd12, 32'h0);
        eret = 1'b0;
        checkOutput("eret_mtc0_status", status_o, 32'h0040_0001);

        applyStimulus(5'd16, 32'hFFFF_FFFF);
        readReg(5'd16, rd);
        checkOutput("config_mask", rd, 32'h8000_0007);
        applyStimulus(5'd13, 32'hFFFF_FFFF);
        readReg(5'd13, rd);
        checkOutput("cause_mask", rd, 32'h0000_0300);
        applyStimulus(5'd13, 32'h0);
        readReg(5'd10, rd);
        checkOutput("unmapped_read", rd, 32'h0);

        applyStimulus(5'd12, 32'h0000_1001);
        hw_int = 6'b000100;
        tick();
        checkOutput("hw_1cyc", {30'd0, cause_o[12], int_req}, 32'h0);
        tick();
        checkOutput("hw_2cyc", {30'd0, cause_o[12], int_req}, 32'h3);
        hw_int = 6'b000000;
        tick();
        checkOutput("hw_hold", {30'd0, cause_o[12], int_req}, 32'h3);
        tick();
        checkOutput("hw_clear", {30'd0, cause_o[12], int_req}, 32'h0);

        applyStimulus(5'd9, 32'h55);
        readReg(5'd9, rd);
        checkOutput("count_pre_rst", rd, 32'h55);
        rst = 1'b0;
        readReg(5'd9, rd);
        checkOutput("async_rst_count", rd, 32'h0);
        checkOutput("async_rst_status", status_o, 32'h0040_0000);
        checkOutput("async_rst_intreq", {31'd0, int_req}, 32'h0);
        readReg(5'd15, rd);
        checkOutput("async_rst_prid", rd, 32'h0000_4220);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
        $finish;
    end

endmodule

// File: doc/cp0_timer_regfile.md
Name: cp0_timer_regfile

Overview:
Parametrised next-generation CP0 register file for the pipelined MIPS core. It adds a Count/Compare timer interrupt, synchronised hardware interrupt inputs and a single precise exception-commit/ERET port. It also adds masked MTC0 writes and an interrupt-request output for the exception unit. It sits beside the MEM/WB stage: MFC0 reads via raddr, and MTC0, exception commit and ERET are applied at the clock edge.

Parameters:
WIDTH, 32, datapath width of every CP0 register
HW_INT_NUM, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_INT_NUM-1:2]; unused IP bits read 0
COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (1..16)
PRID_VALUE, 32'h0000_4220, constant PRId readback
CONFIG_RST, 32'h8000_0000, Config reset value

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset (0 = reset)
hw_int  in  HW_INT_NUM  asynchronous hardware interrupt lines, level-sensitive
mtc0_we  in  1  MTC0 write strobe
waddr  in  5  MTC0 register number
wdata  in  WIDTH  MTC0 write data
raddr  in  5  MFC0 register number
rdata  out  WIDTH  MFC0 read data, combinational
exc_valid  in  1  exception committed this cycle
exc_code  in  5  ExcCode of the committed exception
exc_bd  in  1  faulting instruction is in a delay slot
exc_pc  in  WIDTH  PC of the faulting instruction
exc_badvaddr  in  WIDTH  faulting virtual address
eret  in  1  ERET committed this cycle
status_o  out  WIDTH  Status register
cause_o  out  WIDTH  Cause register
epc_o  out  WIDTH  EPC register
int_req  out  1  interrupt pending and enabled
timer_int  out  1  Cause.TI
kernel_mode  out  1  Status.EXL

Behaviour:
- Reset (rst=0, async): BadVAddr=0, Count=0, Compare=0, Status=32'h0040_0000 (BEV=1), Cause=0, EPC=0, Config=CONFIG_RST. Divider phase=0, sync flops=0. All outputs derive from these values: int_req=0, timer_int=0, kernel_mode=0.
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config. Any other raddr reads 0.
- MTC0 write masks:
  - Status: only IM[15:8], EXL[1], IE[0].
  - Cause: only IP[9:8].
  - Count, Compare, EPC: full width.
  - Config: only K0[2:0].
  - BadVAddr, PRId: read-only, writes ignored.
- Read timing: rdata shows pre-edge values. A read of a register written in the same cycle returns the old value.
- Count:
  - Divider counts 0..COUNT_DIV-1; Count+1 on terminal phase; wraps 32'hFFFF_FFFF -> 0.
  - MTC0 to Count loads wdata, resets the divider phase and suppresses that cycle's increment.
- Timer:
  - When Count==Compare after the edge update, Cause.TI (bit 30) sets. It is sticky; only an MTC0 to Compare clears it.
  - If a Compare write and a match occur in the same cycle, the write wins: TI=0.
  - Cause.IP[7] = TI OR synced hw_int[5] (when HW_INT_NUM=6).
- Hardware interrupts: each line passes through a 2-flop synchroniser. Cause.IP[7:2] is updated every cycle from the synced lines, so a change on hw_int appears in cause_o 2 cycles later.
- int_req = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]), combinational.
- Exception commit (exc_valid=1):
  - If Status.EXL==0: EPC = exc_bd ? exc_pc-4 : exc_pc; Cause.BD = exc_bd.
  - If Status.EXL==1: EPC and BD are unchanged (nested exception).
  - Always: Status.EXL=1; Cause.ExcCode=exc_code.
  - BadVAddr = exc_badvaddr only for exc_code 4 (AdEL) or 5 (AdES).
- ERET: Status.EXL=0. EPC is unchanged.
- Same-cycle priority: exc_valid > eret > mtc0_we.
  - A lower-priority event on Status/Cause/EPC/BadVAddr is dropped.
  - MTC0 to Count/Compare/Config is still performed under eret, but dropped under exc_valid.
- Count increments and the synchroniser run regardless of EXL.

Optional Feature:
Macro CP0_TIMER_INT_EN.
- Defined: Count/Compare/TI behave as above.
- Undefined:
  - Compare is not implemented and reads 0; writes to it are ignored.
  - TI is constant 0 and timer_int=0.
  - Cause.IP[7] = synced hw_int[5] only.
  - Count still runs.

Test Plan:
- Reset: rst=0 mid-run with Count=32'h55 -> immediately Count=0, status_o=32'h0040_0000, int_req=0, rdata(raddr=15)=32'h0000_4220.
- Timer: COUNT_DIV=2; MTC0 Count=0, Compare=5, Status=32'h0000_8001 -> TI=1 and int_req=1 after 10 cycles. MTC0 Compare=100 -> TI=0 next cycle.
- Same-cycle collision: Compare write in the exact cycle Count hits Compare -> TI stays 0.
- Delay-slot exception: exc_valid with exc_bd=1, exc_pc=32'hBFC0_0104, exc_code=5, exc_badvaddr=32'h1234_5679 -> EPC=32'hBFC0_0100, Cause[31]=1, Cause[6:2]=5, BadVAddr=32'h1234_5679, EXL=1.
- Nested exception, then ERET: a second exc_valid with exc_pc=32'h8000_0180 -> EPC unchanged. eret -> EXL=0. Simultaneous eret + MTC0 Status=0 -> EXL=0, IE unchanged.
- Hardware interrupt: hw_int[2] pulses high with IM[4]=1, IE=1 -> cause_o[12]=1 two cycles later and int_req=1. Drop the line -> both clear two cycles later.
